mbssoc_bus_arbiter: RTL and testbench

Parametrised shared-memory bus arbiter for the multi-core MBSsoc. It replaces the fixed two-core bus controller. It accepts read/write requests from CORE_NUM cores and grants the single RAM port to one core at a time using round-robin priority. It stalls losing cores through per-core pause lines, supports a configurable number of RAM wait states, and enforces a maximum consecutive-hold limit so that no core can starve the others.

---
 rtl/mbssoc_bus_arbiter_if.sv | 26 ++
 rtl/mbssoc_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mbssoc_bus_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mbssoc_bus_arbiter_if.sv
// rtl/mbssoc_bus_arbiter_if.sv - core request lines and shared RAM port seen by the bus arbiter
interface mbssoc_bus_arbiter_if #(
  parameter int CORE_NUM   = 2,
  parameter int SEL_WIDTH  = 1,
  parameter int ADDR_WIDTH = 32
);
  logic [2*CORE_NUM-1:0]          ctrl_bus;
  logic [CORE_NUM*ADDR_WIDTH-1:0] addr_bus;
  logic [CORE_NUM-1:0]            cpu_pause;
  logic                           ram_re;
  logic                           ram_we;
  logic [ADDR_WIDTH-1:0]          ram_addr;
  logic                           grant_valid;
  logic [SEL_WIDTH-1:0]           grant_idx;
  logic                           rw_conflict;

  modport master (
    output ctrl_bus, addr_bus,
    input  cpu_pause, ram_re, ram_we, ram_addr, grant_valid, grant_idx, rw_conflict
  );

  modport slave (
    input  ctrl_bus, addr_bus,
    output cpu_pause, ram_re, ram_we, ram_addr, grant_valid, grant_idx, rw_conflict
  );
endinterface

// File: rtl/mbssoc_bus_arbiter.sv
// rtl/mbssoc_bus_arbiter.sv - round-robin arbiter granting one shared RAM port to CORE_NUM cores
// Strobes follow the owner's live inputs; wait states and a hold limit bound each tenure.
module mbssoc_bus_arbiter #(
  parameter int CORE_NUM   = 2,
  parameter int SEL_WIDTH  = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_WAIT   = 0,
  parameter int MAX_HOLD   = 4
) (
  input  logic                clk,
  input  logic                rst,
  mbssoc_bus_arbiter_if.slave bus
);
  localparam int WAIT_W = (RAM_WAIT > 0) ? $clog2(RAM_WAIT + 1) : 1;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(RAM_WAIT);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_RST  = SEL_WIDTH'(CORE_NUM - 1);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                r_state;
  logic [SEL_WIDTH-1:0]  r_owner;
  logic [SEL_WIDTH-1:0]  r_last_owner;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;

  logic [CORE_NUM-1:0]   w_re;
  logic [CORE_NUM-1:0]   w_we;
  logic [CORE_NUM-1:0]   w_req;
  logic [CORE_NUM-1:0]   w_owner_oh;
  logic [ADDR_WIDTH-1:0] w_addr [CORE_NUM];

  logic [SEL_WIDTH-1:0]  w_pick_base;
  logic [SEL_WIDTH-1:0]  w_pick;
  logic [SEL_WIDTH-1:0]  w_cand;
  logic                  w_pick_hit;

  logic                  w_access;
  logic                  w_own_req;
  logic                  w_own_re;
  logic                  w_own_we;
  logic                  w_wait_done;
  logic                  w_complete;
  logic                  w_others;

  always_comb begin
    w_re       = '0;
    w_we       = '0;
    w_req      = '0;
    w_owner_oh = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      w_re[i]       = bus.ctrl_bus[2*i];
      w_we[i]       = bus.ctrl_bus[2*i+1];
      w_req[i]      = bus.ctrl_bus[2*i] | bus.ctrl_bus[2*i+1];
      w_addr[i]     = bus.addr_bus[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_owner_oh[i] = (r_owner == SEL_WIDTH'(i));
    end
  end

  // Scan starts just past the core that last used the bus; in ACCESS that is
  // the current owner, since any handover follows its completion or abort.
  always_comb begin
    w_pick_base = (r_state == ST_ACCESS) ? r_owner : r_last_owner;
    w_pick      = w_pick_base;
    w_pick_hit  = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= CORE_NUM; k++) begin
      w_cand = SEL_WIDTH'((int'(w_pick_base) + k) % CORE_NUM);
      if (!w_pick_hit && w_req[w_cand]) begin
        w_pick     = w_cand;
        w_pick_hit = 1'b1;
      end
    end
  end

  assign w_access    = (r_state == ST_ACCESS);
  assign w_own_re    = w_re[r_owner];
  assign w_own_we    = w_we[r_owner];
  assign w_own_req   = w_req[r_owner];
  assign w_wait_done = (r_wait_cnt == WAIT_LAST);
  assign w_complete  = w_access & w_wait_done & w_own_req;
  assign w_others    = |(w_req & ~w_owner_oh);

  assign bus.grant_valid = w_access;
  assign bus.grant_idx   = w_access ? r_owner : '0;
  assign bus.ram_addr    = w_access ? w_addr[r_owner] : '0;
  assign bus.ram_we      = w_access & w_own_we;
  assign bus.ram_re      = w_access & w_own_re & ~w_own_we;
  assign bus.rw_conflict = w_access & w_own_re & w_own_we;
  assign bus.cpu_pause   = w_req & ~(w_owner_oh & {CORE_NUM{w_complete}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= LAST_RST;
      r_wait_cnt   <= '0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_owner    <= w_pick;
            r_wait_cnt <= '0;
            r_hold_cnt <= '0;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!w_own_req) begin
            r_last_owner <= r_owner;
            r_wait_cnt   <= '0;
            r_hold_cnt   <= '0;
            if (|w_req) begin
              r_owner <= w_pick;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end else begin
            r_last_owner <= r_owner;
            r_wait_cnt   <= '0;
            if (w_others && (r_hold_cnt == HOLD_LAST)) begin
              r_owner    <= w_pick;
              r_hold_cnt <= '0;
            end else if (r_hold_cnt != HOLD_LAST) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbssoc_bus_arbiter.sv
// tb/tb_mbssoc_bus_arbiter.sv - scoreboard bench for mbssoc_bus_arbiter across three configurations
module tb_mbssoc_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int exp;
  int want_addr;

  mbssoc_bus_arbiter_if #(.CORE_NUM(2), .SEL_WIDTH(1), .ADDR_WIDTH(16)) if_a ();
  mbssoc_bus_arbiter_if #(.CORE_NUM(2), .SEL_WIDTH(1), .ADDR_WIDTH(16)) if_b ();
  mbssoc_bus_arbiter_if #(.CORE_NUM(4), .SEL_WIDTH(2), .ADDR_WIDTH(16)) if_c ();

  mbssoc_bus_arbiter #(.CORE_NUM(2), .SEL_WIDTH(1), .ADDR_WIDTH(16), .RAM_WAIT(0), .MAX_HOLD(4))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mbssoc_bus_arbiter #(.CORE_NUM(2), .SEL_WIDTH(1), .ADDR_WIDTH(16), .RAM_WAIT(0), .MAX_HOLD(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mbssoc_bus_arbiter #(.CORE_NUM(4), .SEL_WIDTH(2), .ADDR_WIDTH(16), .RAM_WAIT(2), .MAX_HOLD(4))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic apply_reset;
    rst = 1'b1;
    if_a.ctrl_bus = '0; if_b.ctrl_bus = '0; if_c.ctrl_bus = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_a.ctrl_bus = 4'b0001;
    @(negedge clk); #1;
    n_cmp++; if (if_a.cpu_pause !== 2'b01) begin n_bad++; $display("FAIL rst_pause: got %b want 01", if_a.cpu_pause); end
    n_cmp++; if (if_a.grant_valid !== 1'b0) begin n_bad++; $display("FAIL rst_grant_valid: got %b want 0", if_a.grant_valid); end
    n_cmp++; if (if_a.grant_idx !== 1'b0) begin n_bad++; $display("FAIL rst_grant_idx: got %b want 0", if_a.grant_idx); end
    n_cmp++; if ({if_a.ram_re, if_a.ram_we, if_a.rw_conflict} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b want 000", {if_a.ram_re, if_a.ram_we, if_a.rw_conflict}); end
    n_cmp++; if (if_a.ram_addr !== 16'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", if_a.ram_addr); end
    if_a.ctrl_bus = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    apply_reset();
    if_a.ctrl_bus = 4'b0001;
    if_a.addr_bus = {16'h0000, 16'h0040};
    exp_q.push_back(0);
    #1;
    n_cmp++; if (if_a.cpu_pause !== 2'b01) begin n_bad++; $display("FAIL rd_pause_c1: got %b want 01", if_a.cpu_pause); end
    n_cmp++; if (if_a.grant_valid !== 1'b0) begin n_bad++; $display("FAIL rd_idle_c1: got %b want 0", if_a.grant_valid); end
    @(negedge clk); #1;
    n_cmp++; if (if_a.ram_re !== 1'b1 || if_a.ram_we !== 1'b0) begin n_bad++; $display("FAIL rd_strobe: got re=%b we=%b want re=1 we=0", if_a.ram_re, if_a.ram_we); end
    n_cmp++; if (if_a.ram_addr !== 16'h0040) begin n_bad++; $display("FAIL rd_addr: got %h want 0040", if_a.ram_addr); end
    n_cmp++; if (if_a.cpu_pause[0] !== 1'b0) begin n_bad++; $display("FAIL rd_pause_c2: got %b want 0", if_a.cpu_pause[0]); end
    if ((if_a.ram_re | if_a.ram_we) && !if_a.cpu_pause[if_a.grant_idx] && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_cmp++; if (if_a.grant_idx !== 1'(exp)) begin n_bad++; $display("FAIL rd_owner: got %0d want %0d", if_a.grant_idx, exp); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rd_done: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    if_a.ctrl_bus = '0;
    @(negedge clk);
  endtask

  task automatic test_hold_limit;
    apply_reset();
    if_a.addr_bus = {16'h0200, 16'h0100};
    if_a.ctrl_bus = 4'b0101;
    for (int i = 0; i < 4; i++) exp_q.push_back(0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1);
    exp_q.push_back(0);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk); #1;
      if ((if_a.ram_re | if_a.ram_we) && !if_a.cpu_pause[if_a.grant_idx]) begin
        exp = exp_q.pop_front();
        want_addr = (exp == 0) ? 32'h0100 : 32'h0200;
        n_cmp++; if (if_a.grant_idx !== 1'(exp)) begin n_bad++; $display("FAIL hold_owner: got %0d want %0d", if_a.grant_idx, exp); end
        n_cmp++; if (if_a.ram_addr !== 16'(want_addr)) begin n_bad++; $display("FAIL hold_addr: got %h want %h", if_a.ram_addr, 16'(want_addr)); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL hold_timeout: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    if_a.ctrl_bus = '0;
  endtask

  task automatic test_reset_conflict;
    apply_reset();
    if_a.addr_bus = {16'h0300, 16'h0010};
    if_a.ctrl_bus = 4'b1100;
    #1;
    n_cmp++; if (if_a.grant_valid !== 1'b0) begin n_bad++; $display("FAIL cf_idle: got %b want 0", if_a.grant_valid); end
    @(negedge clk); #1;
    n_cmp++; if (if_a.grant_idx !== 1'b1) begin n_bad++; $display("FAIL cf_owner: got %b want 1", if_a.grant_idx); end
    n_cmp++; if ({if_a.ram_we, if_a.ram_re, if_a.rw_conflict} !== 3'b101) begin n_bad++; $display("FAIL cf_strobes: got we,re,cf=%b want 101", {if_a.ram_we, if_a.ram_re, if_a.rw_conflict}); end
    n_cmp++; if (if_a.ram_addr !== 16'h0300) begin n_bad++; $display("FAIL cf_addr: got %h want 0300", if_a.ram_addr); end
    if_a.ctrl_bus = 4'b1101;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({if_a.ram_we, if_a.ram_re, if_a.rw_conflict, if_a.grant_valid} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_drop: got %b want 0000", {if_a.ram_we, if_a.ram_re, if_a.rw_conflict, if_a.grant_valid}); end
    n_cmp++; if (if_a.cpu_pause !== 2'b11) begin n_bad++; $display("FAIL mid_rst_pause: got %b want 11", if_a.cpu_pause); end
    @(negedge clk);
    if_a.ctrl_bus = 4'b1001;
    rst = 1'b0;
    #1;
    n_cmp++; if (if_a.grant_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: got %b want 0", if_a.grant_valid); end
    @(negedge clk); #1;
    n_cmp++; if (if_a.grant_idx !== 1'b0 || if_a.ram_re !== 1'b1) begin n_bad++; $display("FAIL post_rst_first: got idx=%b re=%b want idx=0 re=1", if_a.grant_idx, if_a.ram_re); end
    if_a.ctrl_bus = '0;
  endtask

  task automatic test_contention;
    rst = 1'b1;
    if_b.addr_bus = {16'h0B00, 16'h0A00};
    if_b.ctrl_bus = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(i % 2);
    #1;
    n_cmp++; if (if_b.grant_valid !== 1'b0) begin n_bad++; $display("FAIL alt_idle: got %b want 0", if_b.grant_valid); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (!((if_b.ram_re | if_b.ram_we) && !if_b.cpu_pause[if_b.grant_idx])) begin
        n_bad++; $display("FAIL alt_bubble: got no completion in cycle %0d want completion", c);
      end else begin
        exp = exp_q.pop_front();
        if (if_b.grant_idx !== 1'(exp)) begin n_bad++; $display("FAIL alt_owner: got %0d want %0d", if_b.grant_idx, exp); end
      end
    end
    exp_q.delete();
    if_b.ctrl_bus = '0;
  endtask

  task automatic test_wait_states;
    apply_reset();
    if_c.addr_bus = {16'h0444, 16'h0333, 16'h0100, 16'h0111};
    if_c.ctrl_bus = 8'b0000_1000;
    exp_q.push_back(1);
    #1;
    n_cmp++; if (if_c.cpu_pause !== 4'b0010) begin n_bad++; $display("FAIL ws_pause_idle: got %b want 0010", if_c.cpu_pause); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (if_c.ram_we !== 1'b1 || if_c.ram_re !== 1'b0) begin n_bad++; $display("FAIL ws_strobe: got we=%b re=%b want we=1 re=0", if_c.ram_we, if_c.ram_re); end
      n_cmp++; if (if_c.cpu_pause[1] !== (k != 2)) begin n_bad++; $display("FAIL ws_pause: got %b want %b at wait %0d", if_c.cpu_pause[1], (k != 2), k); end
      if ((if_c.ram_re | if_c.ram_we) && !if_c.cpu_pause[if_c.grant_idx] && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        n_cmp++; if (if_c.grant_idx !== 2'(exp) || if_c.ram_addr !== 16'h0100) begin n_bad++; $display("FAIL ws_owner: got %0d/%h want %0d/0100", if_c.grant_idx, if_c.ram_addr, exp); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ws_done: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_abort_rotation;
    @(negedge clk);
    if_c.ctrl_bus = '0;
    #1;
    n_cmp++; if ({if_c.ram_we, if_c.ram_re} !== 2'b00) begin n_bad++; $display("FAIL ab_drop1: got %b want 00", {if_c.ram_we, if_c.ram_re}); end
    @(negedge clk);
    if_c.ctrl_bus = 8'b0101_0101;
    #1;
    n_cmp++; if (if_c.grant_valid !== 1'b0) begin n_bad++; $display("FAIL ab_idle: got %b want 0", if_c.grant_valid); end
    @(negedge clk); #1;
    n_cmp++; if (if_c.grant_idx !== 2'd2 || if_c.cpu_pause !== 4'b1111) begin n_bad++; $display("FAIL ab_owner2: got idx=%0d pause=%b want 2/1111", if_c.grant_idx, if_c.cpu_pause); end
    @(negedge clk);
    if_c.ctrl_bus = 8'b0100_0101;
    #1;
    n_cmp++; if (if_c.ram_re !== 1'b0 || if_c.grant_idx !== 2'd2 || if_c.cpu_pause !== 4'b1011) begin n_bad++; $display("FAIL ab_abort: got re=%b idx=%0d pause=%b want 0/2/1011", if_c.ram_re, if_c.grant_idx, if_c.cpu_pause); end
    @(negedge clk);
    if_c.ctrl_bus = 8'b0101_0101;
    for (int i = 0; i < 4; i++) exp_q.push_back(3);
    for (int i = 0; i < 4; i++) exp_q.push_back(0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1);
    exp_q.push_back(2);
    #1;
    n_cmp++; if (if_c.grant_idx !== 2'd3 || if_c.ram_re !== 1'b1) begin n_bad++; $display("FAIL ab_next: got idx=%0d re=%b want 3/1", if_c.grant_idx, if_c.ram_re); end
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk); #1;
      if ((if_c.ram_re | if_c.ram_we) && !if_c.cpu_pause[if_c.grant_idx]) begin
        exp = exp_q.pop_front();
        n_cmp++; if (if_c.grant_idx !== 2'(exp)) begin n_bad++; $display("FAIL rot_owner: got %0d want %0d", if_c.grant_idx, exp); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rot_timeout: got %0d pending want 0", exp_q.size()); exp_q.delete(); end
    if_c.ctrl_bus = '0;
  endtask

  initial begin
    rst = 1'b1;
    if_a.ctrl_bus = '0; if_a.addr_bus = '0;
    if_b.ctrl_bus = '0; if_b.addr_bus = '0;
    if_c.ctrl_bus = '0; if_c.addr_bus = '0;
    test_reset();
    test_single_read();
    test_hold_limit();
    test_reset_conflict();
    test_contention();
    test_wait_states();
    test_abort_rotation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
